barcode_finder: RTL

BARCODE_FINDER -- requirements
Module: barcode_finder

---
 rtl/barcode_finder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/barcode_finder.sv
// Scans a 64x64 one-bit image row-major and reports the first barcode seen on
// ten consecutive rows with identical end column and kernel/stride/dilation.
module barcode_finder #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_mem_rd,
  output logic [11:0]       o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_barcode_found,
  output logic [1:0]        o_kernel,
  output logic [1:0]        o_stride,
  output logic [1:0]        o_dilation
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [10:0] START_C = 11'b11010011100;
  localparam logic [10:0] K3_C    = 11'b10010011000;
  localparam logic [10:0] CODE1_C = 11'b11001101100;
  localparam logic [10:0] CODE2_C = 11'b11001100110;
  localparam logic [12:0] STOP_C  = 13'b1100011101011;
  localparam logic [3:0]  ROWS_C  = 4'd10;

  function automatic logic [1:0] decode_sd(input logic [10:0] code);
    logic [1:0] v;
    v = 2'd0;
    if (code == CODE1_C) v = 2'd1;
    else if (code == CODE2_C) v = 2'd2;
    return v;
  endfunction

  state_t      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [56:0] w_q, w_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        hit_row_q, hit_row_d;
  logic [5:0]  prev_col_q, prev_col_d;
  logic [5:0]  prev_ksd_q, prev_ksd_d;
  logic        found_q, found_d;
  logic [1:0]  kernel_q, kernel_d;
  logic [1:0]  stride_q, stride_d;
  logic [1:0]  dil_q, dil_d;
  logic        vld_p0, vld_p1;
  logic [5:0]  col_p0, col_p1;

  logic        active;
  logic [1:0]  s_dec, d_dec;
  logic [5:0]  ksd;
  logic        pat_ok, match_now, row_end, hit_now;
  logic        pix;

  assign active = (state_q == SCAN) || (state_q == DRAIN);
  assign pix    = i_mem_data[DATA_W-1];
  assign s_dec  = decode_sd(w_q[34:24]);
  assign d_dec  = decode_sd(w_q[23:13]);
  assign ksd    = {2'd3, s_dec, d_dec};
  assign pat_ok = (w_q[56:46] == START_C) && (w_q[45:35] == K3_C) &&
                  (s_dec != 2'd0) && (d_dec != 2'd0) && (w_q[12:0] == STOP_C);
  assign match_now = active && vld_p1 && pat_ok && !hit_row_q;
  assign row_end   = active && vld_p1 && (col_p1 == 6'd63);
  assign hit_now   = match_now && (cnt_d == ROWS_C);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    w_d        = w_q;
    cnt_d      = cnt_q;
    hit_row_d  = hit_row_q;
    prev_col_d = prev_col_q;
    prev_ksd_d = prev_ksd_q;
    found_d    = found_q;
    kernel_d   = kernel_q;
    stride_d   = stride_q;
    dil_d      = dil_q;

    // column 0 restarts the window so a pattern can never straddle two rows
    if (active && vld_p0) begin
      if (col_p0 == 6'd0) w_d = {56'd0, pix};
      else                w_d = {w_q[55:0], pix};
    end

    if (match_now) begin
      hit_row_d  = 1'b1;
      prev_col_d = col_p1;
      prev_ksd_d = ksd;
      // a nonzero count already implies the row above matched
      if ((cnt_q != 4'd0) && (prev_col_q == col_p1) && (prev_ksd_q == ksd))
        cnt_d = cnt_q + 4'd1;
      else
        cnt_d = 4'd1;
    end else if (row_end && !hit_row_q) begin
      cnt_d = 4'd0;
    end
    if (row_end) hit_row_d = 1'b0;

    if (hit_now) begin
      found_d  = 1'b1;
      kernel_d = ksd[5:4];
      stride_d = ksd[3:2];
      dil_d    = ksd[1:0];
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d    = SCAN;
          addr_d     = 12'd0;
          w_d        = '0;
          cnt_d      = 4'd0;
          hit_row_d  = 1'b0;
          prev_col_d = 6'd0;
          prev_ksd_d = 6'd0;
          found_d    = 1'b0;
          kernel_d   = 2'd0;
          stride_d   = 2'd0;
          dil_d      = 2'd0;
        end
      end
      SCAN: begin
        // a hit leaves nothing worth evaluating, so it skips straight to DONE
        if (hit_now)                  state_d = DONE;
        else if (addr_q == 12'd4095)  state_d = DRAIN;
        else                          addr_d  = addr_q + 12'd1;
      end
      DRAIN: begin
        if (hit_now || !vld_p0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      w_q        <= '0;
      cnt_q      <= '0;
      hit_row_q  <= 1'b0;
      prev_col_q <= '0;
      prev_ksd_q <= '0;
      found_q    <= 1'b0;
      kernel_q   <= '0;
      stride_q   <= '0;
      dil_q      <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      w_q        <= w_d;
      cnt_q      <= cnt_d;
      hit_row_q  <= hit_row_d;
      prev_col_q <= prev_col_d;
      prev_ksd_q <= prev_ksd_d;
      found_q    <= found_d;
      kernel_q   <= kernel_d;
      stride_q   <= stride_d;
      dil_q      <= dil_d;
      vld_p0     <= (state_q == SCAN);
      vld_p1     <= vld_p0;
    end
  end

  // p0: column of the pixel on the data bus; p1: column of the pixel now in W
  always_ff @(posedge i_clk) begin
    col_p0 <= addr_q[5:0];
    col_p1 <= col_p0;
  end

  assign o_mem_rd        = (state_q == SCAN);
  assign o_mem_addr      = addr_q;
  assign o_busy          = active;
  assign o_done          = (state_q == DONE);
  assign o_barcode_found = found_q;
  assign o_kernel        = kernel_q;
  assign o_stride        = stride_q;
  assign o_dilation      = dil_q;

endmodule
